// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Purpose : Instruction fetch stage with PC, IF/ID register and warm-up bubbles.
//           Optional HALT detection enabled by defining IF_HALT_DETECT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter int                     PC_WIDTH      = 8,
    parameter int                     INSTR_WIDTH   = 16,
    parameter int                     WARMUP_CYCLES = 3,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD      = 16'b00101_000_00000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction_input,
    output logic [PC_WIDTH-1:0]    pc_increment_address,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [INSTR_WIDTH-1:0] if_id_instruction,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic                   if_id_valid,
    output logic [15:0]            fetch_count,
    output logic                   halted
);

    localparam logic [1:0] S_WARM = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam int          WARM_LAST_I = (WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1;
    localparam logic [3:0]  WARM_LAST   = 4'(WARM_LAST_I);
    localparam logic        NO_WARMUP   = (WARMUP_CYCLES == 0);

    logic [1:0]             state_q, state_d;
    logic [3:0]             warm_q, warm_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    ifpc_q, ifpc_d;
    logic                   valid_q, valid_d;
    logic [15:0]            fcount_q, fcount_d;
    logic                   halted_q, halted_d;

    logic                   w_run_active;
    logic                   w_normal_fetch;
    logic                   w_halt_fetch;

    // With no warm-up, the state after reset already fetches like S_RUN.
    assign w_run_active   = (state_q == S_RUN) || ((state_q == S_WARM) && NO_WARMUP);
    assign w_normal_fetch = w_run_active && !branch_taken && !flush && !stall;

`ifdef IF_HALT_DETECT_EN
    assign w_halt_fetch = w_normal_fetch &&
                          (instruction_input[INSTR_WIDTH-1 -: 5] == 5'b11111);
`else
    assign w_halt_fetch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WARM;
            warm_q   <= 4'd0;
            pc_q     <= '0;
            instr_q  <= NOP_WORD;
            ifpc_q   <= '0;
            valid_q  <= 1'b0;
            fcount_q <= 16'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            valid_q  <= valid_d;
            fcount_q <= fcount_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        case (state_q)
            S_WARM: begin
                warm_d = warm_q + 4'd1;
                if (NO_WARMUP) begin
                    state_d = w_halt_fetch ? S_HALT : S_RUN;
                end else if (warm_q == WARM_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_halt_fetch) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_WARM;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fcount_d = fcount_q;
        if (w_run_active) begin
            if (branch_taken) begin
                pc_d    = branch_target;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end else if (flush) begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (!stall) begin
                    pc_d = pc_q + 1'b1;
                end
            end else if (!stall) begin
                instr_d = instruction_input;
                ifpc_d  = pc_q;
                valid_d = 1'b1;
                if (fcount_q != 16'hFFFF) begin
                    fcount_d = fcount_q + 16'd1;
                end
                // A HALT word freezes the PC at its own address.
                if (w_halt_fetch) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
        end else begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            if (state_q == S_HALT) begin
                halted_d = 1'b1;
            end else begin
                pc_d = '0;
            end
        end
    end

    assign pc_increment_address = pc_q;
    assign if_id_instruction    = instr_q;
    assign if_id_pc             = ifpc_q;
    assign if_id_valid          = valid_q;
    assign fetch_count          = fcount_q;
    assign halted               = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Purpose : Directed self-checking bench for if_stage with a small ROM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [15:0] NOP = 16'b00101_000_00000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction_input;
    logic [7:0]  pc_increment_address;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [15:0] if_id_instruction;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic [15:0] fetch_count;
    logic        halted;

    logic [15:0] rom [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign instruction_input = rom[pc_increment_address];

    if_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_input    (instruction_input),
        .pc_increment_address (pc_increment_address),
        .stall                (stall),
        .flush                (flush),
        .branch_taken         (branch_taken),
        .branch_target        (branch_target),
        .if_id_instruction    (if_id_instruction),
        .if_id_pc             (if_id_pc),
        .if_id_valid          (if_id_valid),
        .fetch_count          (fetch_count),
        .halted               (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] instr,
                              input logic [7:0] ipc, input logic v);
        check({tag, ".instr"}, 32'(if_id_instruction), 32'(instr));
        check({tag, ".ifpc"},  32'(if_id_pc),          32'(ipc));
        check({tag, ".valid"}, 32'(if_id_valid),       32'(v));
    endtask

    task automatic warmup_seq(input string tag);
        for (int k = 0; k < 3; k++) begin
            step();
            check({tag, ".warm_valid"}, 32'(if_id_valid), 32'd0);
            check({tag, ".warm_instr"}, 32'(if_id_instruction), 32'(NOP));
            check({tag, ".warm_pc"}, 32'(pc_increment_address), 32'd0);
        end
        step();
        check_ifid({tag, ".first"}, 16'h6133, 8'h00, 1'b1);
        check({tag, ".first_pc"}, 32'(pc_increment_address), 32'd1);
        check({tag, ".first_fc"}, 32'(fetch_count), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h4000 | 16'(i);
        rom[0] = 16'h6133;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        step();
        rst = 1'b0;
        check("rst.pc", 32'(pc_increment_address), 32'd0);
        check_ifid("rst", NOP, 8'h00, 1'b0);
        check("rst.fc", 32'(fetch_count), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);

        warmup_seq("warm");

        // Advance from pc=1 to pc=5.
        for (int k = 0; k < 4; k++) step();
        check("run.pc5", 32'(pc_increment_address), 32'd5);
        check_ifid("run.rom4", 16'h4004, 8'h04, 1'b1);
        check("run.fc5", 32'(fetch_count), 32'd5);

        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall.pc", 32'(pc_increment_address), 32'd5);
            check_ifid("stall", 16'h4004, 8'h04, 1'b1);
            check("stall.fc", 32'(fetch_count), 32'd5);
        end
        stall = 1'b0;
        step();
        check_ifid("unstall", 16'h4005, 8'h05, 1'b1);
        check("unstall.pc", 32'(pc_increment_address), 32'd6);
        check("unstall.fc", 32'(fetch_count), 32'd6);

        step();
        check("pre_br.pc", 32'(pc_increment_address), 32'd7);
        branch_taken = 1'b1; branch_target = 8'h20; flush = 1'b1; stall = 1'b1;
        step();
        branch_taken = 1'b0; flush = 1'b0; stall = 1'b0;
        check("br.pc", 32'(pc_increment_address), 32'h20);
        check("br.instr", 32'(if_id_instruction), 32'(NOP));
        check("br.valid", 32'(if_id_valid), 32'd0);
        check("br.fc", 32'(fetch_count), 32'd7);
        step();
        check_ifid("br.target", 16'h4020, 8'h20, 1'b1);
        check("br.next_pc", 32'(pc_increment_address), 32'h21);
        check("br.fc2", 32'(fetch_count), 32'd8);

        branch_taken = 1'b1; branch_target = 8'hFF;
        step();
        branch_taken = 1'b0;
        check("toff.pc", 32'(pc_increment_address), 32'hFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("wrap.pc", 32'(pc_increment_address), 32'h00);
        check("wrap.instr", 32'(if_id_instruction), 32'(NOP));
        check("wrap.valid", 32'(if_id_valid), 32'd0);
        check("wrap.fc", 32'(fetch_count), 32'd8);
        step();
        check_ifid("wrap.rom0", 16'h6133, 8'h00, 1'b1);
        check("wrap.next_pc", 32'(pc_increment_address), 32'd1);

        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        check("fl_st.pc", 32'(pc_increment_address), 32'd1);
        check("fl_st.valid", 32'(if_id_valid), 32'd0);
        step();
        check_ifid("fl_st.rom1", 16'h4001, 8'h01, 1'b1);
        check("fl_st.fc", 32'(fetch_count), 32'd10);

        // Reset must win over a simultaneous branch request.
        rst = 1'b1; branch_taken = 1'b1; branch_target = 8'h55;
        step();
        rst = 1'b0; branch_taken = 1'b0;
        check("mrst.pc", 32'(pc_increment_address), 32'd0);
        check("mrst.fc", 32'(fetch_count), 32'd0);
        check_ifid("mrst", NOP, 8'h00, 1'b0);
        warmup_seq("rewarm");

        rom[2] = 16'hF800;
        step();
        check_ifid("halt.rom1", 16'h4001, 8'h01, 1'b1);
        step();
        check_ifid("halt.fetch", 16'hF800, 8'h02, 1'b1);
        check("halt.fc", 32'(fetch_count), 32'd3);
`ifdef IF_HALT_DETECT_EN
        check("halt.pc", 32'(pc_increment_address), 32'd2);
        check("halt.flag", 32'(halted), 32'd1);
        for (int k = 0; k < 20; k++) begin
            branch_taken = k[0]; branch_target = 8'h40; flush = k[1];
            step();
            check("halted.pc", 32'(pc_increment_address), 32'd2);
            check("halted.valid", 32'(if_id_valid), 32'd0);
            check("halted.flag", 32'(halted), 32'd1);
        end
        branch_taken = 1'b0; flush = 1'b0;
`else
        check("nohalt.pc", 32'(pc_increment_address), 32'd3);
        check("nohalt.flag", 32'(halted), 32'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            check("nohalt.pc_run", 32'(pc_increment_address), 32'(4 + k));
            check("nohalt.valid", 32'(if_id_valid), 32'd1);
            check("nohalt.flag_run", 32'(halted), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
